// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : LEGv8 ID/EX register with ALU-control decode and forwarding
// Revision    : 1.0
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [10:0]       id_opcode,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              load_use_stall,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_cnt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_imm
);

  localparam logic [REG_W-1:0] C_ZERO   = REG_W'(ZERO_REG);
  localparam logic [10:0]      C_OP_ADD = 11'b10001011000;
  localparam logic [10:0]      C_OP_SUB = 11'b11001011000;
  localparam logic [10:0]      C_OP_AND = 11'b10001010000;
  localparam logic [10:0]      C_OP_ORR = 11'b10101010000;

  logic              r_valid, r_reg_write, r_mem_read, r_mem_write;
  logic              r_mem_to_reg, r_branch, r_alu_src;
  logic [3:0]        r_alu_cnt;
  logic [REG_W-1:0]  r_rn, r_rm, r_rd;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;

  logic [3:0]        w_alu_cnt;
  logic              w_stall;
  logic              w_ctl_en;
  logic [DATA_W-1:0] w_fwd_a, w_fwd_b;

  always_comb begin
    w_alu_cnt = 4'b0010;
    case (id_alu_op)
      2'b00: w_alu_cnt = 4'b0010;
      2'b01: w_alu_cnt = 4'b0111;
      2'b11: w_alu_cnt = 4'b0010;
      default: begin
        case (id_opcode)
          C_OP_ADD: w_alu_cnt = 4'b0010;
          C_OP_SUB: w_alu_cnt = 4'b0110;
          C_OP_AND: w_alu_cnt = 4'b0000;
          C_OP_ORR: w_alu_cnt = 4'b0001;
          default:  w_alu_cnt = 4'b0111;
        endcase
      end
    endcase
  end

  // A load in EX whose destination is read by the ID instruction must wait a cycle.
  assign w_stall = r_valid & r_mem_read & (r_rd != C_ZERO) & id_valid &
                   ((id_rn == r_rd) | (id_rm == r_rd));
  assign w_ctl_en = id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_cnt    <= 4'b0000;
      r_rn         <= '0;
      r_rm         <= '0;
      r_rd         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
    end else if (flush || (!hold && w_stall)) begin
      // Bubble: only the control bits matter downstream, data fields are left as-is.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
    end else if (!hold) begin
      r_valid      <= id_valid;
      r_reg_write  <= w_ctl_en & id_reg_write;
      r_mem_read   <= w_ctl_en & id_mem_read;
      r_mem_write  <= w_ctl_en & id_mem_write;
      r_mem_to_reg <= w_ctl_en & id_mem_to_reg;
      r_branch     <= w_ctl_en & id_branch;
      r_alu_src    <= w_ctl_en & id_alu_src;
      r_alu_cnt    <= w_alu_cnt;
      r_rn         <= id_rn;
      r_rm         <= id_rm;
      r_rd         <= id_rd;
      r_rd1        <= id_rd1;
      r_rd2        <= id_rd2;
      r_imm        <= id_imm;
    end
  end

  always_comb begin
    w_fwd_a = r_rd1;
    if (exmem_reg_write && (exmem_rd == r_rn) && (r_rn != C_ZERO))
      w_fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd == r_rn) && (r_rn != C_ZERO))
      w_fwd_a = memwb_data;
  end

  always_comb begin
    w_fwd_b = r_rd2;
    if (exmem_reg_write && (exmem_rd == r_rm) && (r_rm != C_ZERO))
      w_fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd == r_rm) && (r_rm != C_ZERO))
      w_fwd_b = memwb_data;
  end

  assign load_use_stall = w_stall;
  assign alu_in1        = w_fwd_a;
  assign alu_in2        = r_alu_src ? r_imm : w_fwd_b;
  assign ex_store_data  = w_fwd_b;
  assign alu_cnt        = r_alu_cnt;
  assign ex_valid       = r_valid;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_mem_to_reg  = r_mem_to_reg;
  assign ex_branch      = r_branch;
  assign ex_rd          = r_rd;
  assign ex_imm         = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : directed and randomized self-checking bench for id_ex_stage
// Revision       : 1.0
// ============================================================================
module tb_id_ex_stage;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  logic        clk = 1'b0;
  logic        rst_n, hold, flush, id_valid;
  logic [63:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic [1:0]  id_alu_op;
  logic [10:0] id_opcode;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_data;
  logic        load_use_stall;
  logic [63:0] alu_in1, alu_in2, ex_store_data, ex_imm;
  logic [3:0]  alu_cnt;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  // Reference model of the EX-side instruction slot
  logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_br, m_src;
  logic [3:0]  m_cnt;
  logic [4:0]  m_rn, m_rm, m_rd;
  logic [63:0] m_rd1, m_rd2, m_imm;
  logic        exp_stall;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(64), .REG_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_opcode(id_opcode),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .load_use_stall(load_use_stall), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_cnt(alu_cnt), .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_rd(ex_rd), .ex_imm(ex_imm)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, ex_valid, 0);
    check({tag, "_ctl"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}, 0);
  endtask

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic [1:0] op, input logic [10:0] opc, input logic mr);
    id_valid = 1'b1; id_rn = rn; id_rm = rm; id_rd = rd;
    id_alu_op = op; id_opcode = opc; id_mem_read = mr;
    id_mem_to_reg = mr; id_reg_write = 1'b1; id_mem_write = 1'b0; id_branch = 1'b0;
    id_alu_src = 1'b0;
  endtask

  function automatic logic [3:0] ref_cnt(input logic [1:0] op, input logic [10:0] opc);
    if (op != 2'b10) return (op == 2'b01) ? 4'b0111 : 4'b0010;
    if (opc == OP_ADD) return 4'b0010;
    if (opc == OP_SUB) return 4'b0110;
    if (opc == OP_AND) return 4'b0000;
    if (opc == OP_ORR) return 4'b0001;
    return 4'b0111;
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] regval);
    if (idx == 5'd31) return regval;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_data;
    return regval;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] tbl [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
    return tbl[$urandom_range(4)];
  endfunction

  function automatic logic [10:0] pick_opc();
    logic [10:0] tbl [4] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
    int k = $urandom_range(4);
    if (k == 4) return 11'($urandom);
    return tbl[k];
  endfunction

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rn = '0; id_rm = '0; id_rd = '0; id_alu_op = '0; id_opcode = '0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_branch = 0;
    exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = '0; memwb_data = '0;
    repeat (2) tick();
    check("rst_valid", ex_valid, 0);
    check("rst_cnt", alu_cnt, 0);
    check("rst_in1", alu_in1, 0);
    @(negedge clk); rst_n = 1'b1;

    // R-type decode through all ALU encodings
    set_id(5'd1, 5'd2, 5'd3, 2'b10, OP_ADD, 1'b0);
    id_rd1 = 64'd20; id_rd2 = 64'd22;
    tick();
    check("add_in1", alu_in1, 20);
    check("add_in2", alu_in2, 22);
    check("add_cnt", alu_cnt, 4'b0010);
    check("add_valid", {ex_valid, ex_reg_write}, 2'b11);
    id_opcode = OP_SUB; tick(); check("sub_cnt", alu_cnt, 4'b0110);
    id_opcode = OP_AND; tick(); check("and_cnt", alu_cnt, 4'b0000);
    id_opcode = OP_ORR; tick(); check("orr_cnt", alu_cnt, 4'b0001);
    id_alu_op = 2'b01;  tick(); check("cbz_cnt", alu_cnt, 4'b0111);
    id_alu_op = 2'b11; id_alu_src = 1'b1; id_imm = 64'd123;
    tick();
    check("imm_in2", alu_in2, 123);
    check("imm_store", ex_store_data, 22);
    check("imm_cnt", alu_cnt, 4'b0010);

    // Forwarding priority and XZR exclusion
    set_id(5'd5, 5'd6, 5'd7, 2'b10, OP_ADD, 1'b0);
    id_rd1 = 64'd100;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 64'd42;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_data = 64'd7;
    #1 check("fwd_exmem", alu_in1, 42);
    exmem_reg_write = 0;
    #1 check("fwd_memwb", alu_in1, 7);
    memwb_rd = 5'd6;
    #1 check("fwd_b_store", ex_store_data, 7);
    exmem_reg_write = 1; id_rn = 5'd31; exmem_rd = 5'd31; memwb_rd = 5'd31;
    tick();
    check("fwd_xzr", alu_in1, 100);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Load-use stall, bubble, then the held instruction enters EX
    set_id(5'd1, 5'd0, 5'd3, 2'b00, OP_ADD, 1'b1);
    tick();
    set_id(5'd3, 5'd2, 5'd4, 2'b10, OP_ADD, 1'b0);
    #1 check("lu_stall", load_use_stall, 1);
    tick();
    check_bubble("lu_bubble");
    check("lu_stall_off", load_use_stall, 0);
    tick();
    check("lu_capture", {ex_valid, ex_rd}, {1'b1, 5'd4});

    // Flush beats hold; hold freezes contents
    flush = 1; hold = 1;
    tick();
    check_bubble("flush_hold");
    flush = 0; hold = 0;
    set_id(5'd1, 5'd2, 5'd9, 2'b10, OP_SUB, 1'b0);
    id_rd1 = 64'd55;
    tick();
    hold = 1; id_rd = 5'd12; id_rd1 = 64'd66; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_keep", {ex_valid, ex_reg_write, ex_rd, alu_cnt}, {1'b1, 1'b1, 5'd9, 4'b0110});
      check("hold_in1", alu_in1, 55);
    end
    hold = 0;
    tick();
    check("hold_resume", {ex_valid, ex_reg_write, ex_rd}, {1'b0, 1'b0, 5'd12});

    // Invalid ID slot carries no controls
    id_valid = 1'b0; id_reg_write = 1'b1; id_mem_read = 1'b1;
    tick();
    check_bubble("invalid");

    // Mid-stream asynchronous reset, then normal first edge
    set_id(5'd1, 5'd2, 5'd3, 2'b10, OP_ORR, 1'b0);
    id_rd1 = 64'd77; id_rd2 = 64'd88;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {ex_valid, ex_reg_write, ex_rd, alu_cnt}, 0);
    check("async_rst_in1", alu_in1, 0);
    check("async_rst_in2", alu_in2, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("post_rst", {ex_valid, alu_cnt}, {1'b1, 4'b0001});
    check("post_rst_in2", alu_in2, 88);

    // Randomized phase against the reference model
    @(negedge clk); rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0; m_src = 0;
    m_cnt = 0; m_rn = 0; m_rm = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      flush = ($urandom_range(9) == 0);
      hold = ($urandom_range(5) == 0);
      id_valid = ($urandom_range(3) != 0);
      id_rd1 = {$urandom, $urandom}; id_rd2 = {$urandom, $urandom};
      id_imm = {$urandom, $urandom};
      id_rn = pick_reg(); id_rm = pick_reg(); id_rd = pick_reg();
      id_alu_op = 2'($urandom); id_opcode = pick_opc();
      id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(2) == 0); id_mem_write = 1'($urandom);
      id_mem_to_reg = 1'($urandom); id_branch = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = pick_reg(); exmem_result = {$urandom, $urandom};
      memwb_reg_write = 1'($urandom); memwb_rd = pick_reg(); memwb_data = {$urandom, $urandom};
      #1;
      exp_stall = m_valid && m_mr && (m_rd != 5'd31) && id_valid &&
                  (id_rn == m_rd || id_rm == m_rd);
      check("rnd_stall", load_use_stall, exp_stall);
      if (flush || (!hold && exp_stall)) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0; m_src = 0;
      end else if (!hold) begin
        m_valid = id_valid;
        m_rw = id_valid && id_reg_write;   m_mr = id_valid && id_mem_read;
        m_mw = id_valid && id_mem_write;   m_m2r = id_valid && id_mem_to_reg;
        m_br = id_valid && id_branch;      m_src = id_valid && id_alu_src;
        m_cnt = ref_cnt(id_alu_op, id_opcode);
        m_rn = id_rn; m_rm = id_rm; m_rd = id_rd;
        m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      end
      tick();
      check("rnd_ctl", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
            {m_valid, m_rw, m_mr, m_mw, m_m2r, m_br});
      if (m_valid) begin
        check("rnd_cnt_rd", {alu_cnt, ex_rd}, {m_cnt, m_rd});
        check("rnd_in1", alu_in1, ref_fwd(m_rn, m_rd1));
        check("rnd_in2", alu_in2, m_src ? m_imm : ref_fwd(m_rm, m_rd2));
        check("rnd_store", ex_store_data, ref_fwd(m_rm, m_rd2));
        check("rnd_imm", ex_imm, m_imm);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection for the pipelined LEGv8 core; sits directly upstream of the ALU and drives its input_1, input_2 and ALUCnt.
- Captures decoded operands and control from ID, decodes the 4-bit ALU control, detects load-use hazards, inserts bubbles, honours flush/hold, and forwards results from EX/MEM and MEM/WB.

Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register-index width
- ZERO_REG, 31, XZR index; never forwarded, never a hazard source

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global freeze, e.g. memory wait
- flush  in  1  taken branch; kill instruction entering EX
- id_valid  in  1  ID slot holds a real instruction
- id_rd1, id_rd2  in  DATA_W  register-file read data (Rn, Rm/Rt)
- id_imm  in  DATA_W  sign-extended immediate
- id_rn, id_rm, id_rd  in  REG_W  register indices
- id_alu_op  in  2  main-control ALUOp
- id_opcode  in  11  instruction[31:21]
- id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control
- exmem_reg_write  in  1;  exmem_rd  in  REG_W;  exmem_result  in  DATA_W  EX/MEM forward source
- memwb_reg_write  in  1;  memwb_rd  in  REG_W;  memwb_data  in  DATA_W  MEM/WB forward source
- load_use_stall  out  1  to hazard logic: hold PC and IF/ID
- alu_in1, alu_in2  out  DATA_W  to ALU input_1/input_2
- alu_cnt  out  4  to ALU ALUCnt
- ex_store_data  out  DATA_W  forwarded Rm/Rt for STUR
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each
- ex_rd  out  REG_W;  ex_imm  out  DATA_W  (branch offset)

Behaviour:
- Reset, async on rst_n low: all registered state 0, so ex_valid=0, all ex_* controls 0, alu_cnt=4'b0000, ex_rd=0, and alu_in1/alu_in2/ex_store_data=0.
- ALU control decode, registered with the instruction:
  - ALUOp 00 -> 0010
  - ALUOp 01 -> 0111 (pass input_2, CBZ)
  - ALUOp 11 -> 0010 (ADDI)
  - ALUOp 10 uses opcode: 10001011000 ADD -> 0010; 11001011000 SUB -> 0110; 10001010000 AND -> 0000; 10101010000 ORR -> 0001; any other -> 0111
- Load-use, combinational: load_use_stall = ex_valid & ex_mem_read & ex_rd!=ZERO_REG & id_valid & (id_rn==ex_rd | id_rm==ex_rd).
- Register update per edge, priority high to low:
  1. flush: load bubble (ex_valid and all ex_* controls 0; data fields don't-care)
  2. hold: keep contents
  3. load_use_stall: load bubble
  4. otherwise: capture ID fields; ex_valid=id_valid
  - id_valid=0 captures with all control bits forced to 0.
- Forwarding, combinational on registered Rn/Rm, applied to operand A (Rn) and operand B (Rm):
  - If exmem_reg_write and exmem_rd==idx and idx!=ZERO_REG, use exmem_result.
  - Else if memwb_reg_write and memwb_rd==idx and idx!=ZERO_REG, use memwb_data.
  - Else use the registered read data.
  - EX/MEM beats MEM/WB when both match.
- Operand outputs:
  - alu_in1 = forwarded A.
  - alu_in2 = ex_alu_src ? ex_imm : forwarded B.
  - ex_store_data = forwarded B always.
- Latency: ID inputs appear on outputs 1 cycle later. Forward selection is same-cycle, with no added latency.
- Bubble outputs: data outputs hold harmless values; downstream qualifies everything with the control bits.
- Mid-operation reset clears immediately and asynchronously. The first post-reset edge behaves normally.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 before the next edge; ex_valid=0.
- R-type decode: id_rd1=20, id_rd2=22, ALUOp=10, opcode ADD -> next cycle alu_in1=20, alu_in2=22, alu_cnt=0010. Repeat with SUB, AND, ORR -> 0110/0000/0001. ALUOp=01 -> 0111; id_alu_src=1, imm=123 -> alu_in2=123.
- Forwarding: registered Rn=X5 with exmem_rd=5 (result 42) and memwb_rd=5 (data 7), both reg_write=1 -> alu_in1=42. Drop exmem_reg_write -> alu_in1=7. Rn=X31 with both matching -> register value, not forwarded.
- Load-use: LDUR X3 in EX followed by ADD X4,X3,X2 in ID -> load_use_stall=1 for one cycle. Next edge: ex_valid=0 and controls 0. Following edge (ID held) captures the ADD.
- Flush vs hold: assert flush and hold together -> bubble loaded. Assert hold alone -> all ex_* outputs unchanged for N cycles, then resume.
- Invalid slot: id_valid=0 with id_reg_write=1 -> ex_reg_write=0, ex_valid=0.
